hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: owns the EX..W destination-tag pipe and derives EX forwarding selects, decode stalls and fetch enables.
// Latency: every control output is combinational from registered tags plus current D/EX inputs; tags advance one entry per edge.
// Backpressure: MemStall freezes both pipes; a load-use or writeback-read hazard holds IF/ID and drops a bubble into EX.
module hazard_scoreboard #(
  parameter int NFWD     = 3,
  parameter int LOAD_RDY = 3,
  parameter int RF_WT    = 0,
  parameter int ZERO_REG = 1,
  parameter int AW       = 5,
  parameter int FWW      = $clog2(NFWD + 1),
  parameter int CNTW     = 16
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [AW-1:0]   RA0_D,
  input  logic [AW-1:0]   RA1_D,
  input  logic            RS1Used_D,
  input  logic            RS2Used_D,
  input  logic [AW-1:0]   WA_D,
  input  logic            WEN_D,
  input  logic            Load_D,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            Taken,
  input  logic            MemStall,
  output logic            PCWrite,
  output logic            IMRead,
  output logic            FDWrite,
  output logic            DEFlush,
  output logic [FWW-1:0]  FW1,
  output logic [FWW-1:0]  FW2,
  output logic [CNTW-1:0] StallCnt
);

  // Tag pipe: entry 0 is EX, entry NFWD is writeback
  logic [NFWD:0]         vld_q, vld_d;
  logic [NFWD:0]         load_q, load_d;
  logic [NFWD:0][AW-1:0] addr_q, addr_d;

  // Source operands of the instruction currently in EX
  logic [AW-1:0]   ra0_e_q, ra0_e_d;
  logic [AW-1:0]   ra1_e_q, ra1_e_d;
  logic            rs1u_e_q, rs1u_e_d;
  logic            rs2u_e_q, rs2u_e_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NFWD:0] hit0_d, hit1_d;
  logic [NFWD:1] hit0_e, hit1_e;
  logic          lu_stall, wb_stall, hs, redirect;
  logic [FWW-1:0] fw1, fw2;

  // Hard-wired r0 never produces a match when ZERO_REG is set
  function automatic logic addr_ok(input logic [AW-1:0] r);
    return (ZERO_REG == 0) || (r != '0);
  endfunction

  // Which entries write each decode source and each EX source
  always_comb begin
    hit0_d = '0;
    hit1_d = '0;
    hit0_e = '0;
    hit1_e = '0;
    for (int k = 0; k <= NFWD; k++) begin
      hit0_d[k] = vld_q[k] && (addr_q[k] == RA0_D) && addr_ok(RA0_D);
      hit1_d[k] = vld_q[k] && (addr_q[k] == RA1_D) && addr_ok(RA1_D);
    end
    for (int k = 1; k <= NFWD; k++) begin
      hit0_e[k] = vld_q[k] && (addr_q[k] == ra0_e_q) && addr_ok(ra0_e_q);
      hit1_e[k] = vld_q[k] && (addr_q[k] == ra1_e_q) && addr_ok(ra1_e_q);
    end
  end

  // Decode-stage stall: load data not yet forwardable, or reading a value still in W without write-through
  always_comb begin
    lu_stall = 1'b0;
    for (int k = 0; k <= NFWD; k++) begin
      if (load_q[k] && (k + 1 < LOAD_RDY) &&
          ((RS1Used_D && hit0_d[k]) || (RS2Used_D && hit1_d[k])))
        lu_stall = 1'b1;
    end
    wb_stall = (RF_WT == 0) &&
               ((RS1Used_D && hit0_d[NFWD]) || (RS2Used_D && hit1_d[NFWD]));
  end

  assign hs       = (lu_stall || wb_stall) && !MemStall;
  assign redirect = Jump || (Branch && Taken);

  // Forwarding select: scan oldest to youngest so the youngest matching stage wins
  always_comb begin
    fw1 = '0;
    fw2 = '0;
    for (int k = NFWD; k >= 1; k--) begin
      if (rs1u_e_q && hit0_e[k]) fw1 = FWW'(k);
      if (rs2u_e_q && hit1_e[k]) fw2 = FWW'(k);
    end
  end

  // Next state: freeze on MemStall, bubble on hazard, otherwise capture decode and shift
  always_comb begin
    vld_d    = vld_q;
    load_d   = load_q;
    addr_d   = addr_q;
    ra0_e_d  = ra0_e_q;
    ra1_e_d  = ra1_e_q;
    rs1u_e_d = rs1u_e_q;
    rs2u_e_d = rs2u_e_q;
    cnt_d    = cnt_q;
    if (!MemStall) begin
      for (int k = 1; k <= NFWD; k++) begin
        vld_d[k]  = vld_q[k-1];
        load_d[k] = load_q[k-1];
        addr_d[k] = addr_q[k-1];
      end
      if (hs) begin
        vld_d[0]  = 1'b0;
        load_d[0] = 1'b0;
        addr_d[0] = '0;
        rs1u_e_d  = 1'b0;
        rs2u_e_d  = 1'b0;
        if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
      end else begin
        vld_d[0]  = ~WEN_D;
        load_d[0] = Load_D;
        addr_d[0] = WA_D;
        ra0_e_d   = RA0_D;
        ra1_e_d   = RA1_D;
        rs1u_e_d  = RS1Used_D;
        rs2u_e_d  = RS2Used_D;
      end
    end
  end

  // State registers; reset clears every tag and the counter at once
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_q    <= '0;
      load_q   <= '0;
      addr_q   <= '0;
      ra0_e_q  <= '0;
      ra1_e_q  <= '0;
      rs1u_e_q <= 1'b0;
      rs2u_e_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      load_q   <= load_d;
      addr_q   <= addr_d;
      ra0_e_q  <= ra0_e_d;
      ra1_e_q  <= ra1_e_d;
      rs1u_e_q <= rs1u_e_d;
      rs2u_e_q <= rs2u_e_d;
      cnt_q    <= cnt_d;
    end
  end

  assign PCWrite  = !MemStall && !hs;
  assign FDWrite  = !MemStall && !hs;
  assign IMRead   = !MemStall && !hs && !redirect;
  assign DEFlush  = hs;
  assign FW1      = fw1;
  assign FW2      = fw2;
  assign StallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance, a write-through instance and a 2-bit-counter instance share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later, well before the next edge.
// All expected values are hand-derived constants.
module tb_hazard_scoreboard;

  logic       CLK;
  logic       RSTN;
  logic [4:0] RA0_D, RA1_D, WA_D;
  logic       RS1Used_D, RS2Used_D, WEN_D, Load_D;
  logic       Jump, Branch, Taken, MemStall;

  logic        m_pcw, m_imr, m_fdw, m_def;
  logic [1:0]  m_fw1, m_fw2;
  logic [15:0] m_cnt;
  logic        w_pcw, w_imr, w_fdw, w_def;
  logic [1:0]  w_fw1, w_fw2;
  logic [15:0] w_cnt;
  logic        s_pcw, s_imr, s_fdw, s_def;
  logic [1:0]  s_fw1, s_fw2;
  logic [1:0]  s_cnt;

  int n_chk = 0;
  int n_err = 0;

  hazard_scoreboard u_dut (
    .CLK(CLK), .RSTN(RSTN), .RA0_D(RA0_D), .RA1_D(RA1_D),
    .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D), .WA_D(WA_D), .WEN_D(WEN_D),
    .Load_D(Load_D), .Jump(Jump), .Branch(Branch), .Taken(Taken), .MemStall(MemStall),
    .PCWrite(m_pcw), .IMRead(m_imr), .FDWrite(m_fdw), .DEFlush(m_def),
    .FW1(m_fw1), .FW2(m_fw2), .StallCnt(m_cnt));

  hazard_scoreboard #(.RF_WT(1)) u_wt (
    .CLK(CLK), .RSTN(RSTN), .RA0_D(RA0_D), .RA1_D(RA1_D),
    .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D), .WA_D(WA_D), .WEN_D(WEN_D),
    .Load_D(Load_D), .Jump(Jump), .Branch(Branch), .Taken(Taken), .MemStall(MemStall),
    .PCWrite(w_pcw), .IMRead(w_imr), .FDWrite(w_fdw), .DEFlush(w_def),
    .FW1(w_fw1), .FW2(w_fw2), .StallCnt(w_cnt));

  hazard_scoreboard #(.CNTW(2)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .RA0_D(RA0_D), .RA1_D(RA1_D),
    .RS1Used_D(RS1Used_D), .RS2Used_D(RS2Used_D), .WA_D(WA_D), .WEN_D(WEN_D),
    .Load_D(Load_D), .Jump(Jump), .Branch(Branch), .Taken(Taken), .MemStall(MemStall),
    .PCWrite(s_pcw), .IMRead(s_imr), .FDWrite(s_fdw), .DEFlush(s_def),
    .FW1(s_fw1), .FW2(s_fw2), .StallCnt(s_cnt));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [4:0] a0, input logic u0, input logic [4:0] a1,
                     input logic u1, input logic [4:0] wa, input logic wen_n, input logic ld);
    RA0_D = a0; RS1Used_D = u0; RA1_D = a1; RS2Used_D = u1;
    WA_D = wa; WEN_D = wen_n; Load_D = ld;
  endtask

  task automatic nop();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  initial begin
    RSTN = 1'b1;
    nop();
    Jump = 1'b0; Branch = 1'b0; Taken = 1'b0; MemStall = 1'b0;
    #1 RSTN = 1'b0;
    #2;
    check("rst_pcw", m_pcw, 1);
    check("rst_imr", m_imr, 1);
    check("rst_fdw", m_fdw, 1);
    check("rst_def", m_def, 0);
    check("rst_fw1", m_fw1, 0);
    check("rst_fw2", m_fw2, 0);
    check("rst_cnt", m_cnt, 0);
    tick();
    RSTN = 1'b1;
    tick();

    // ADD r5 then SUB r5 back-to-back: forward from M1
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0); #1;
    check("d1_pcw", m_pcw, 1);
    tick();
    drv(5'd5, 1'b1, 5'd4, 1'b1, 5'd6, 1'b0, 1'b0); #1;
    check("d1_def", m_def, 0);
    tick();
    nop(); #1;
    check("d1_fw1", m_fw1, 1);
    check("d1_fw2", m_fw2, 0);
    drain();

    // One gap, consumer on operand 2: forward from M2
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0); tick();
    nop(); tick();
    drv(5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 1'b0); #1;
    check("d2_def", m_def, 0);
    tick();
    nop(); #1;
    check("d2_fw2", m_fw2, 2);
    check("d2_fw1", m_fw1, 0);
    drain();

    // Two gaps: forward from W
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0); tick();
    nop(); tick();
    nop(); tick();
    drv(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0); #1;
    check("d3_pcw", m_pcw, 1);
    tick();
    nop(); #1;
    check("d3_fw1", m_fw1, 3);
    drain();

    // Two writers of r5: the younger one wins
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0); tick();
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0); tick();
    drv(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0); tick();
    nop(); #1;
    check("yw_fw1", m_fw1, 1);
    drain();

    // LW r7 then ADD r7: two stall cycles, then forward from W
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1); tick();
    drv(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0); #1;
    check("lu_def0", m_def, 1);
    check("lu_pcw0", m_pcw, 0);
    check("lu_imr0", m_imr, 0);
    check("lu_fdw0", m_fdw, 0);
    check("lu_fw10", m_fw1, 0);
    check("lu_cnt0", m_cnt, 0);
    tick(); #1;
    check("lu_def1", m_def, 1);
    check("lu_cnt1", m_cnt, 1);
    check("lu_fw11", m_fw1, 0);
    tick(); #1;
    check("lu_def2", m_def, 0);
    check("lu_pcw2", m_pcw, 1);
    check("lu_cnt2", m_cnt, 2);
    check("lu_fw12", m_fw1, 0);
    tick();
    nop(); #1;
    check("lu_fw1", m_fw1, 3);
    check("lu_cnt", m_cnt, 2);
    check("sat_cnt_a", s_cnt, 2);
    drain();

    // Producer r3 in W while decode reads r3: one stall unless write-through
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0); tick();
    nop(); tick();
    nop(); tick();
    nop(); tick();
    drv(5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0); #1;
    check("wb_def", m_def, 1);
    check("wb_pcw", m_pcw, 0);
    check("wt_pcw", w_pcw, 1);
    check("wt_def", w_def, 0);
    tick(); #1;
    check("wb_def1", m_def, 0);
    check("wb_pcw1", m_pcw, 1);
    check("wb_cnt", m_cnt, 3);
    check("sat_cnt_b", s_cnt, 3);
    drain();

    // Load to r0 followed by r0 consumer: no match with hard-wired r0
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); tick();
    drv(5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b0, 1'b0); #1;
    check("z_def", m_def, 0);
    check("z_pcw", m_pcw, 1);
    tick();
    nop(); #1;
    check("z_fw1", m_fw1, 0);
    check("z_fw2", m_fw2, 0);
    drain();

    // Redirects kill the fetch read only
    Jump = 1'b1; #1;
    check("rd_j_imr", m_imr, 0);
    check("rd_j_pcw", m_pcw, 1);
    check("rd_j_fdw", m_fdw, 1);
    Jump = 1'b0; Branch = 1'b1; #1;
    check("rd_nt_imr", m_imr, 1);
    Taken = 1'b1; #1;
    check("rd_bt_imr", m_imr, 0);
    check("rd_bt_def", m_def, 0);
    Branch = 1'b0; Taken = 1'b0;
    tick();

    // MemStall for 4 cycles in the middle of a load-use hazard
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1); tick();
    drv(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0); #1;
    check("ms_def0", m_def, 1);
    check("ms_cnt0", m_cnt, 3);
    tick();
    MemStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ms_pcw", m_pcw, 0);
      check("ms_imr", m_imr, 0);
      check("ms_fdw", m_fdw, 0);
      check("ms_def", m_def, 0);
      check("ms_cnt", m_cnt, 4);
      tick();
    end
    MemStall = 1'b0; #1;
    check("ms_resume", m_def, 1);
    check("ms_cnt4", m_cnt, 4);
    tick(); #1;
    check("ms_def_end", m_def, 0);
    check("ms_pcw_end", m_pcw, 1);
    check("ms_cnt5", m_cnt, 5);
    check("sat_cnt_c", s_cnt, 3);
    tick();
    nop(); #1;
    check("ms_fw1", m_fw1, 3);
    drain();

    // Reset asserted in the middle of a stall clears everything at once
    drv(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1); tick();
    drv(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0); tick(); #1;
    check("mr_def", m_def, 1);
    check("mr_cnt", m_cnt, 6);
    check("sat_cnt_d", s_cnt, 3);
    RSTN = 1'b0; #1;
    check("mr_cnt0", m_cnt, 0);
    check("mr_scnt0", s_cnt, 0);
    check("mr_pcw", m_pcw, 1);
    check("mr_def0", m_def, 0);
    check("mr_fw1", m_fw1, 0);
    #1 RSTN = 1'b1;
    tick(); #1;
    check("mr_pcw_after", m_pcw, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
